if_id_fifo: RTL and testbench
=============================

Name: if_id_fifo

Overview:
- Small instruction queue between the fetch stage and the decode stage.
- Captures every non-squashed fetch response (PC, instruction word, exception flags) on the fetch data-ok pulse and holds it until decode takes it.
- Drives the fetch stall input so that a full queue makes fetch discard and re-fetch, and never overwrites an entry.
- Flushed as a whole on exception or ERET redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, 1, pointer width, equal to log2(DEPTH); count width is PTR_W+1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch data-ok pulse; candidate entry this cycle
- in_pc  in  32  fetched PC; value 0 marks a squashed or bubble response
- in_inst  in  32  fetched instruction (already zeroed by fetch for reserved or squashed words)
- in_flags  in  5  {interrupt, BD, addr_err, tlb_refill, tlb_invalid}
- fetch_stall  out  1  queue cannot accept this cycle; fetch must drop the word and re-fetch the same PC
- out_valid  out  1  head entry present
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- out_flags  out  5  head flags
- out_ready  in  1  decode consumes head this cycle
- flush  in  1  discard all entries (exception or ERET redirect)
- count  out  PTR_W+1  number of valid entries

Behaviour:
- State:
  - mem[DEPTH] entries of 69 bits (32 PC + 32 instruction + 5 flags).
  - wr_ptr and rd_ptr, PTR_W bits each, wrapping modulo DEPTH.
  - cnt, PTR_W+1 bits.
- Reset: wr_ptr=0, rd_ptr=0, cnt=0. Therefore out_valid=0, fetch_stall=0 and count=0. mem contents are don't-care, but out_pc, out_inst and out_flags must read 0 while out_valid=0.
- Accept condition: push = in_valid && (in_pc!=0 || in_flags!=0) && !fetch_stall && !flush.
  - in_pc==0 with flags==0 is a bubble: drop it silently and leave state unchanged.
  - A nonzero flag with pc 0 is still pushed, because the exception must reach decode.
- Pop condition: pop = out_valid && out_ready && !flush.
- Outputs:
  - out_valid = (cnt!=0).
  - out_* are a combinational read of mem[rd_ptr], gated to 0 when cnt==0.
  - Decode sees the head in the same cycle it is stored; there is no empty-queue bypass.
  - Latency from push to out_valid: 1 cycle.
- fetch_stall = (cnt==DEPTH) && !out_ready.
  - This is a combinational path from out_ready; when full, a simultaneous pop frees the slot.
  - fetch_stall must not depend on in_valid (no combinational loop through fetch).
- Update on each clock edge (reset has highest priority):
  - flush: wr_ptr=rd_ptr=0, cnt=0. flush beats push and pop in the same cycle. The word on in_* that cycle is dropped; fetch is being redirected by its own clear input.
  - push only: mem[wr_ptr]<=in_*, wr_ptr+1, cnt+1.
  - pop only: rd_ptr+1, cnt-1.
  - push and pop together: both pointers advance and cnt is unchanged. This is legal at cnt==DEPTH and also at cnt==1, where the pushed entry becomes the head next cycle.
- Invariants (assert in bench):
  - cnt never exceeds DEPTH and never underflows.
  - wr_ptr-rd_ptr ≡ cnt mod DEPTH.
  - pop never occurs when cnt==0.
  - Entries leave in push order with all 69 bits intact.
- Reset mid-operation: queue empties next cycle identically to flush. Any response arriving during the reset cycle is dropped.

Test Plan:
- Reset then idle → out_valid=0, count=0, fetch_stall=0, out_pc=0 for 5 cycles.
- Push pc 0xbfc00000 inst 0x24020001 flags 0, out_ready=1 → next cycle out_valid=1, out_pc=0xbfc00000; the following cycle count=0.
- out_ready=0, push 0xbfc00000 and 0xbfc00004 → count=2, fetch_stall=1.
  - A third in_valid with pc 0xbfc00008 is not stored.
  - Raise out_ready with in_valid 0xbfc00008 → stall drops, count stays 2, dequeue order is ..00, ..04, ..08.
- in_valid with in_pc=0, flags=0 → count unchanged. in_pc=0, flags=5'b00010 (tlb_refill) → entry pushed, out_flags=5'b00010.
- count=2, assert flush together with in_valid pc 0xbfc0000c and out_ready=1 → next cycle count=0, out_valid=0, and 0xbfc0000c never appears at the output.
- 1000 cycles of random push/pop/flush against a reference queue → order, data and count match; pointers wrap correctly past DEPTH-1.

Source files
------------

// File: rtl/if_id_fifo_if.sv
// if_id_fifo_if: fetch/decode handshake bundle for the IF->ID instruction queue.
//   Fetch side : in_valid, in_pc, in_inst, in_flags -> queue; fetch_stall <- queue
//   Decode side: out_valid, out_pc, out_inst, out_flags <- queue; out_ready -> queue
//   Control    : flush -> queue; count <- queue (PTR_W+1 bits)
// The queue uses modport slave; the surrounding pipeline (or a bench) uses master.
interface if_id_fifo_if #(
  parameter int PTR_W = 1
);
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic [4:0]       in_flags;
  logic             fetch_stall;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [4:0]       out_flags;
  logic             out_ready;
  logic             flush;
  logic [PTR_W:0]   count;

  modport slave (
    input  in_valid, in_pc, in_inst, in_flags, out_ready, flush,
    output fetch_stall, out_valid, out_pc, out_inst, out_flags, count
  );

  modport master (
    output in_valid, in_pc, in_inst, in_flags, out_ready, flush,
    input  fetch_stall, out_valid, out_pc, out_inst, out_flags, count
  );
endinterface

// File: rtl/if_id_fifo.sv
// if_id_fifo: DEPTH-entry instruction queue between fetch and decode.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; empties the queue
//   f     - if_id_fifo_if.slave: fetch push (in_*), stall back to fetch,
//           decode head (out_*) with out_ready pop, flush, occupancy count
// Each entry is {pc, inst, flags} (69 bits). The head is a combinational read of
// the storage and is zeroed while empty. A full queue stalls fetch, which drops
// and re-fetches; entries are never overwritten.
module if_id_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  if_id_fifo_if.slave f
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  flags;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             nonempty, push, pop, stall;
  entry_t           head;

  assign nonempty = (cnt_q != '0);

  // Stall depends only on occupancy and out_ready, never on in_valid, so there
  // is no combinational loop back through fetch. A same-cycle pop frees the slot.
  assign stall = (cnt_q == FULL_CNT) && !f.out_ready;

  // pc==0 with no flags is a bubble/squash; a flagged pc 0 still carries an
  // exception to decode and must be kept.
  assign push = f.in_valid && ((f.in_pc != '0) || (f.in_flags != '0)) && !stall && !f.flush;
  assign pop  = nonempty && f.out_ready && !f.flush;

  assign head          = nonempty ? mem_q[rd_ptr_q] : '0;
  assign f.out_valid   = nonempty;
  assign f.out_pc      = head.pc;
  assign f.out_inst    = head.inst;
  assign f.out_flags   = head.flags;
  assign f.fetch_stall = stall;
  assign f.count       = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (f.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the output gate hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= '{pc: f.in_pc, inst: f.in_inst, flags: f.in_flags};
  end
endmodule

// File: tb/tb_if_id_fifo.sv
module tb_if_id_fifo;
  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  if_id_fifo_if #(.PTR_W(PTR_W)) f ();
  if_id_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clk(clk), .reset(reset), .f(f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [4:0] fl, input logic rdy, input logic fl_sh);
    f.in_valid  = v;
    f.in_pc     = pc;
    f.in_inst   = inst;
    f.in_flags  = fl;
    f.out_ready = rdy;
    f.flush     = fl_sh;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (f.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc%0d got %b exp 0", i, f.out_valid); end
      checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL reset_count cyc%0d got %0d exp 0", i, f.count); end
      checks++; if (f.fetch_stall !== 1'b0) begin failures++; $display("FAIL reset_stall cyc%0d got %b exp 0", i, f.fetch_stall); end
      checks++; if (f.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc cyc%0d got %h exp 0", i, f.out_pc); end
      step();
    end
  endtask

  task automatic test_single();
    drive(1, 32'hbfc00000, 32'h24020001, 5'd0, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    checks++; if (f.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", f.out_valid); end
    checks++; if (f.out_pc !== 32'hbfc00000) begin failures++; $display("FAIL single_pc got %h exp bfc00000", f.out_pc); end
    checks++; if (f.out_inst !== 32'h24020001) begin failures++; $display("FAIL single_inst got %h exp 24020001", f.out_inst); end
    step();
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL single_drain_count got %0d exp 0", f.count); end
    checks++; if (f.out_pc !== 32'h0) begin failures++; $display("FAIL single_empty_pc got %h exp 0", f.out_pc); end
  endtask

  task automatic test_full();
    drive(1, 32'hbfc00000, 32'h11111111, 5'd0, 0, 0);
    step();
    drive(1, 32'hbfc00004, 32'h22222222, 5'd0, 0, 0);
    step();
    drive(1, 32'hbfc00008, 32'h33333333, 5'd0, 0, 0);
    #1;
    checks++; if (f.count !== 2'd2) begin failures++; $display("FAIL full_count got %0d exp 2", f.count); end
    checks++; if (f.fetch_stall !== 1'b1) begin failures++; $display("FAIL full_stall got %b exp 1", f.fetch_stall); end
    step();
    #1;
    checks++; if (f.count !== 2'd2) begin failures++; $display("FAIL full_nostore_count got %0d exp 2", f.count); end
    checks++; if (f.out_pc !== 32'hbfc00000) begin failures++; $display("FAIL full_head0 got %h exp bfc00000", f.out_pc); end
    f.out_ready = 1'b1;
    #1;
    checks++; if (f.fetch_stall !== 1'b0) begin failures++; $display("FAIL full_stall_drop got %b exp 0", f.fetch_stall); end
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    checks++; if (f.count !== 2'd2) begin failures++; $display("FAIL full_pushpop_count got %0d exp 2", f.count); end
    checks++; if (f.out_pc !== 32'hbfc00004) begin failures++; $display("FAIL full_head1 got %h exp bfc00004", f.out_pc); end
    step();
    checks++; if (f.out_pc !== 32'hbfc00008) begin failures++; $display("FAIL full_head2 got %h exp bfc00008", f.out_pc); end
    checks++; if (f.out_inst !== 32'h33333333) begin failures++; $display("FAIL full_head2_inst got %h exp 33333333", f.out_inst); end
    step();
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL full_drain got %0d exp 0", f.count); end
  endtask

  task automatic test_bubble();
    drive(1, 32'h0, 32'h0, 5'd0, 0, 0);
    step();
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL bubble_count got %0d exp 0", f.count); end
    drive(1, 32'h0, 32'h0, 5'b00010, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (f.count !== 2'd1) begin failures++; $display("FAIL exc_count got %0d exp 1", f.count); end
    checks++; if (f.out_valid !== 1'b1) begin failures++; $display("FAIL exc_valid got %b exp 1", f.out_valid); end
    checks++; if (f.out_flags !== 5'b00010) begin failures++; $display("FAIL exc_flags got %b exp 00010", f.out_flags); end
    f.out_ready = 1'b1;
    step();
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL exc_drain got %0d exp 0", f.count); end
  endtask

  task automatic test_flush();
    drive(1, 32'hbfc00000, 32'h1, 5'd0, 0, 0);
    step();
    drive(1, 32'hbfc00004, 32'h2, 5'd0, 0, 0);
    step();
    drive(1, 32'hbfc0000c, 32'h3, 5'd0, 1, 1);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL flush_count got %0d exp 0", f.count); end
    checks++; if (f.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b exp 0", f.out_valid); end
    checks++; if (f.out_pc !== 32'h0) begin failures++; $display("FAIL flush_pc got %h exp 0", f.out_pc); end
    step();
    checks++; if (f.out_pc === 32'hbfc0000c || f.count !== 2'd0) begin failures++; $display("FAIL flush_leak pc %h count %0d exp 0/0", f.out_pc, f.count); end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'hbfc00010, 32'h4, 5'd0, 0, 0);
    step();
    drive(1, 32'hbfc00014, 32'h5, 5'd0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (f.count !== 2'd0) begin failures++; $display("FAIL rstmid_count got %0d exp 0", f.count); end
    checks++; if (f.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b exp 0", f.out_valid); end
    // After reset the queue must be usable from pointer 0 again.
    drive(1, 32'hbfc00018, 32'h6, 5'd0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    checks++; if (f.out_pc !== 32'hbfc00018) begin failures++; $display("FAIL rstmid_reuse got %h exp bfc00018", f.out_pc); end
    step();
  endtask

  task automatic test_random();
    logic [68:0] q[$];
    logic [68:0] hd;
    logic        v, rdy, fsh, exp_stall, p_push, p_pop;
    logic [31:0] pc, inst;
    logic [4:0]  fl;
    logic [PTR_W-1:0] pdiff;
    for (int i = 0; i < 1000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      pc   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      inst = $urandom;
      fl   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      rdy  = ($urandom_range(0, 2) != 0);
      fsh  = ($urandom_range(0, 40) == 0);
      drive(v, pc, inst, fl, rdy, fsh);
      #1;
      hd = (q.size() != 0) ? q[0] : 69'd0;
      exp_stall = (q.size() == DEPTH) && !rdy;
      checks++; if (f.count !== 2'(q.size())) begin failures++; $display("FAIL rnd_count cyc%0d got %0d exp %0d", i, f.count, q.size()); end
      checks++; if (f.fetch_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc%0d got %b exp %b", i, f.fetch_stall, exp_stall); end
      checks++; if (f.out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc%0d got %b exp %b", i, f.out_valid, q.size() != 0); end
      checks++; if ({f.out_pc, f.out_inst, f.out_flags} !== hd) begin failures++; $display("FAIL rnd_head cyc%0d got %h exp %h", i, {f.out_pc, f.out_inst, f.out_flags}, hd); end
      pdiff = dut.wr_ptr_q - dut.rd_ptr_q;
      checks++; if (dut.cnt_q > 2'(DEPTH) || pdiff !== dut.cnt_q[PTR_W-1:0]) begin failures++; $display("FAIL rnd_invariant cyc%0d cnt %0d ptrdiff %0d", i, dut.cnt_q, pdiff); end
      p_push = v && (pc != 0 || fl != 0) && !exp_stall && !fsh;
      p_pop  = (q.size() != 0) && rdy && !fsh;
      if (fsh) q.delete();
      else begin
        if (p_pop) void'(q.pop_front());
        if (p_push) q.push_back({pc, inst, fl});
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_full();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
